mmm_mod_exp_ctrl: RTL

MMM_MOD_EXP_CTRL -- requirements
Module: mmm_mod_exp_ctrl

---
 rtl/mmm_mod_exp_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mmm_mod_exp_ctrl.sv
// -----------------------------------------------------------------------------
// mmm_mod_exp_ctrl
//
// Purpose:
//   Modular exponentiation controller, res = x^e mod p. It runs right-to-left
//   square-and-multiply on one shared, externally supplied modular multiplier
//   with a fixed pipeline latency of LAT cycles. Each exponent bit costs
//   exactly LAT+2 cycles: one square issue (SQ), one optional multiply issue
//   (MUL), then waiting until both results have come back.
//
// Parameters:
//   WIDTH - operand / modulus width
//   EW    - exponent width
//   LAT   - multiplier latency in cycles (>= 2)
//
// Ports:
//   i_clk, i_rst        - clock (rising edge), synchronous active-high reset
//   i_valid / o_ready   - request handshake; o_ready is high only when idle
//   i_x, i_e, i_p       - base, exponent, modulus (sampled on accept only)
//   i_m_b               - reduction constant passed through to the multiplier
//   o_mul_vld           - multiplier issue strobe
//   o_mul_a, o_mul_b    - multiplier operands
//   o_mul_m, o_mul_m_b  - latched modulus and reduction constant
//   i_mul_res           - (a*b) mod m for the operands issued LAT cycles ago
//   o_res, o_done       - result (held until the next completion) and
//                         one-cycle completion pulse
// -----------------------------------------------------------------------------
module mmm_mod_exp_ctrl #(
  parameter int WIDTH = 256,
  parameter int EW    = 256,
  parameter int LAT   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_x,
  input  logic [EW-1:0]      i_e,
  input  logic [WIDTH-1:0]   i_p,
  input  logic [WIDTH+2:0]   i_m_b,
  output logic               o_mul_vld,
  output logic [WIDTH-1:0]   o_mul_a,
  output logic [WIDTH-1:0]   o_mul_b,
  output logic [WIDTH-1:0]   o_mul_m,
  output logic [WIDTH+2:0]   o_mul_m_b,
  input  logic [WIDTH-1:0]   i_mul_res,
  output logic [WIDTH-1:0]   o_res,
  output logic               o_done
);

  // The counter holds "cycles since SQ": 1 in MUL, 2..LAT+1 in WAIT.
  localparam int CW = $clog2(LAT + 2);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_SQ  = CW'(LAT);      // square result arrives
  localparam logic [CW-1:0] CNT_MUL = CW'(LAT + 1);  // multiply result arrives

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    MUL  = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   s_q, s_d;     // running square x^(2^i)
  logic [WIDTH-1:0]   c_q, c_d;     // accumulated product
  logic [EW-1:0]      e_q, e_d;     // remaining exponent bits
  logic [WIDTH-1:0]   p_q, p_d;
  logic [WIDTH+2:0]   mb_q, mb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    c_d       = c_q;
    e_d       = e_q;
    p_d       = p_q;
    mb_d      = mb_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    o_ready   = 1'b0;
    o_mul_vld = 1'b0;
    o_mul_a   = s_q;
    o_mul_b   = s_q;
    o_done    = 1'b0;

    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          s_d     = i_x;
          c_d     = WIDTH'(1);
          e_d     = i_e;
          p_d     = i_p;
          mb_d    = i_m_b;
          state_d = (i_e == '0) ? DONE : SQ;
        end
      end

      SQ: begin
        o_mul_vld = 1'b1;
        cnt_d     = CNT_ONE;
        state_d   = MUL;
      end

      // S has not been overwritten yet, so this multiplies by the
      // pre-square value, as right-to-left exponentiation requires.
      MUL: begin
        o_mul_vld = e_q[0];
        o_mul_a   = c_q;
        o_mul_b   = s_q;
        cnt_d     = cnt_q + CNT_ONE;
        state_d   = WAIT;
      end

      WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_SQ) begin
          s_d = i_mul_res;
        end
        if (cnt_q == CNT_MUL) begin
          if (e_q[0]) begin
            c_d = i_mul_res;
          end
          e_d     = e_q >> 1;
          state_d = ((e_q >> 1) == '0) ? DONE : SQ;
        end
      end

      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture the result on entry to DONE so it is already visible during
    // the o_done cycle and holds afterwards.
    if (state_d == DONE) begin
      res_d = c_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      e_q     <= '0;
      p_q     <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      e_q     <= e_d;
      p_q     <= p_d;
      mb_q    <= mb_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign o_mul_m   = p_q;
  assign o_mul_m_b = mb_q;
  assign o_res     = res_q;

endmodule
